// File: rtl/ibuf_pkg.sv
// Shared types, widths and pointer helpers for the ID1->ID2 dual-bank instruction buffer.
// Optional stall counter on the top is enabled with the IBUF_PERF_CNT_EN macro.
package ibuf_pkg;

    localparam int unsigned IBUF_NUM  = 16;
    localparam int unsigned PC_W      = 32;
    localparam int unsigned IR_W      = 32;
    localparam int unsigned BRP_W     = 34;
    localparam int unsigned ECODE_W   = 8;
    localparam int unsigned ROT_MAX_W = 64;

    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [IR_W-1:0]    ir;
        logic [BRP_W-1:0]   brtype_pcpre;
        logic [ECODE_W-1:0] ecode;
    } ibuf_entry_t;

    // Rotate the low n bits of v left by one (bit n-1 wraps to bit 0); n <= ROT_MAX_W.
    function automatic logic [ROT_MAX_W-1:0] onehot_rotl(input logic [ROT_MAX_W-1:0] v,
                                                         input int unsigned         n);
        logic [ROT_MAX_W-1:0] mask;
        mask = (n >= ROT_MAX_W) ? '1 : ((ROT_MAX_W'(1) << n) - ROT_MAX_W'(1));
        return ((v << 1) | (v >> (n - 1))) & mask;
    endfunction

endpackage

// File: rtl/id_inst_buffer_wr_if.sv
// ID1 push / ID2 pop bus of the instruction buffer, including the raw bank arrays for the ID2 read mux.
interface id_inst_buffer_wr_if import ibuf_pkg::*; #(
    parameter int unsigned NUM = IBUF_NUM
);
    logic [1:0]         in_valid;
    logic [PC_W-1:0]    in_pc0;
    logic [PC_W-1:0]    in_pc1;
    logic [IR_W-1:0]    in_ir0;
    logic [IR_W-1:0]    in_ir1;
    logic [BRP_W-1:0]   in_brtype_pcpre0;
    logic [BRP_W-1:0]   in_brtype_pcpre1;
    logic [ECODE_W-1:0] in_ecode0;
    logic [ECODE_W-1:0] in_ecode1;
    logic               in_ready;

    logic [1:0]         out_pop;
    logic [1:0]         out_valid;
    logic               rd_bank;
    logic [NUM-1:0]     a_tail;
    logic [NUM-1:0]     b_tail;

    logic [PC_W-1:0]    a_PC_Buffer           [NUM];
    logic [PC_W-1:0]    b_PC_Buffer           [NUM];
    logic [IR_W-1:0]    a_IR_Buffer           [NUM];
    logic [IR_W-1:0]    b_IR_Buffer           [NUM];
    logic [BRP_W-1:0]   a_brtype_pcpre_Buffer [NUM];
    logic [BRP_W-1:0]   b_brtype_pcpre_Buffer [NUM];
    logic [ECODE_W-1:0] a_ecode_Buffer        [NUM];
    logic [ECODE_W-1:0] b_ecode_Buffer        [NUM];

    modport master (
        output in_valid, in_pc0, in_pc1, in_ir0, in_ir1,
               in_brtype_pcpre0, in_brtype_pcpre1, in_ecode0, in_ecode1, out_pop,
        input  in_ready, out_valid, rd_bank, a_tail, b_tail,
               a_PC_Buffer, b_PC_Buffer, a_IR_Buffer, b_IR_Buffer,
               a_brtype_pcpre_Buffer, b_brtype_pcpre_Buffer, a_ecode_Buffer, b_ecode_Buffer
    );

    modport slave (
        input  in_valid, in_pc0, in_pc1, in_ir0, in_ir1,
               in_brtype_pcpre0, in_brtype_pcpre1, in_ecode0, in_ecode1, out_pop,
        output in_ready, out_valid, rd_bank, a_tail, b_tail,
               a_PC_Buffer, b_PC_Buffer, a_IR_Buffer, b_IR_Buffer,
               a_brtype_pcpre_Buffer, b_brtype_pcpre_Buffer, a_ecode_Buffer, b_ecode_Buffer
    );

endinterface

// File: rtl/ibuf_bank.sv
// One bank of the instruction buffer: entry storage plus one-hot head (write) and tail (read) pointers.
module ibuf_bank import ibuf_pkg::*; #(
    parameter int unsigned NUM = IBUF_NUM
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           flush,
    input  logic           we,
    input  ibuf_entry_t    wdata,
    input  logic           re,
    output logic [NUM-1:0] tail,
    output ibuf_entry_t    mem [NUM]
);

    localparam logic [NUM-1:0] PTR_RST = NUM'(1);

    logic [NUM-1:0] head_q, head_d;
    logic [NUM-1:0] tail_q, tail_d;
    ibuf_entry_t    mem_q [NUM];
    ibuf_entry_t    mem_d [NUM];

    // Flush rewinds the pointers but keeps the stored entries.
    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        mem_d  = mem_q;
        if (flush) begin
            head_d = PTR_RST;
            tail_d = PTR_RST;
        end else begin
            if (we) begin
                for (int unsigned i = 0; i < NUM; i++) begin
                    if (head_q[i]) begin
                        mem_d[i] = wdata;
                    end
                end
                head_d = NUM'(onehot_rotl(ROT_MAX_W'(head_q), NUM));
            end
            if (re) begin
                tail_d = NUM'(onehot_rotl(ROT_MAX_W'(tail_q), NUM));
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q <= PTR_RST;
            tail_q <= PTR_RST;
            for (int unsigned i = 0; i < NUM; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            for (int unsigned i = 0; i < NUM; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    assign tail = tail_q;

    always_comb begin
        for (int unsigned i = 0; i < NUM; i++) begin
            mem[i] = mem_q[i];
        end
    end

endmodule

// File: rtl/id_inst_buffer_wr.sv
// Write side and pointer owner of the dual-bank ID1->ID2 instruction buffer.
// Define IBUF_PERF_CNT_EN to add the saturating perf_stall_cnt output.
module id_inst_buffer_wr import ibuf_pkg::*; #(
    parameter int unsigned NUM   = IBUF_NUM,
    parameter int unsigned CNT_W = 6
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    id_inst_buffer_wr_if.slave  bus
`ifdef IBUF_PERF_CNT_EN
    ,
    output logic [31:0]         perf_stall_cnt
`endif
);

    localparam int unsigned CAP = 2 * NUM;

    logic [CNT_W-1:0] count_q, count_d;
    logic             wr_bank_q, wr_bank_d;
    logic             rd_bank_q, rd_bank_d;

    logic [1:0]       n_push;
    logic [1:0]       n_pop;
    logic             accept;
    logic             we_a, we_b, re_a, re_b;
    ibuf_entry_t      slot0, slot1, wdata_a, wdata_b;
    logic [NUM-1:0]   a_tail, b_tail;
    ibuf_entry_t      a_mem [NUM];
    ibuf_entry_t      b_mem [NUM];

    // Registered-count admission: never looks at in_valid, so no loop back to ID1.
    assign bus.in_ready  = (count_q <= CNT_W'(CAP - 2));
    assign bus.out_valid = {count_q >= CNT_W'(2), count_q != '0};
    assign bus.rd_bank   = rd_bank_q;
    assign bus.a_tail    = a_tail;
    assign bus.b_tail    = b_tail;

    // Only 01 and 11 are legal; 10 degrades to no-op.
    always_comb begin
        n_push = 2'd0;
        n_pop  = 2'd0;
        case (bus.in_valid)
            2'b01:   n_push = 2'd1;
            2'b11:   n_push = 2'd2;
            default: n_push = 2'd0;
        endcase
        case (bus.out_pop)
            2'b01:   n_pop = 2'd1;
            2'b11:   n_pop = 2'd2;
            default: n_pop = 2'd0;
        endcase
    end

    assign slot0 = '{pc: bus.in_pc0, ir: bus.in_ir0,
                     brtype_pcpre: bus.in_brtype_pcpre0, ecode: bus.in_ecode0};
    assign slot1 = '{pc: bus.in_pc1, ir: bus.in_ir1,
                     brtype_pcpre: bus.in_brtype_pcpre1, ecode: bus.in_ecode1};

    // Slot 0 goes to wr_bank, slot 1 to the other bank; same rule for retiring from rd_bank.
    always_comb begin
        accept    = bus.in_ready && (n_push != 2'd0) && !flush;
        we_a      = accept && ((n_push == 2'd2) || !wr_bank_q);
        we_b      = accept && ((n_push == 2'd2) ||  wr_bank_q);
        wdata_a   = wr_bank_q ? slot1 : slot0;
        wdata_b   = wr_bank_q ? slot0 : slot1;
        re_a      = !flush && ((n_pop == 2'd2) || ((n_pop == 2'd1) && !rd_bank_q));
        re_b      = !flush && ((n_pop == 2'd2) || ((n_pop == 2'd1) &&  rd_bank_q));

        count_d   = count_q;
        wr_bank_d = wr_bank_q;
        rd_bank_d = rd_bank_q;
        if (flush) begin
            count_d   = '0;
            wr_bank_d = 1'b0;
            rd_bank_d = 1'b0;
        end else begin
            count_d = count_q + (accept ? CNT_W'(n_push) : '0) - CNT_W'(n_pop);
            if (accept && (n_push == 2'd1)) begin
                wr_bank_d = ~wr_bank_q;
            end
            if (n_pop == 2'd1) begin
                rd_bank_d = ~rd_bank_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q   <= '0;
            wr_bank_q <= 1'b0;
            rd_bank_q <= 1'b0;
        end else begin
            count_q   <= count_d;
            wr_bank_q <= wr_bank_d;
            rd_bank_q <= rd_bank_d;
        end
    end

    ibuf_bank #(.NUM(NUM)) u_bank_a (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .we    (we_a),
        .wdata (wdata_a),
        .re    (re_a),
        .tail  (a_tail),
        .mem   (a_mem)
    );

    ibuf_bank #(.NUM(NUM)) u_bank_b (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .we    (we_b),
        .wdata (wdata_b),
        .re    (re_b),
        .tail  (b_tail),
        .mem   (b_mem)
    );

    // Split the entry structs back into the per-field arrays ID2 expects.
    always_comb begin
        for (int unsigned i = 0; i < NUM; i++) begin
            bus.a_PC_Buffer[i]           = a_mem[i].pc;
            bus.b_PC_Buffer[i]           = b_mem[i].pc;
            bus.a_IR_Buffer[i]           = a_mem[i].ir;
            bus.b_IR_Buffer[i]           = b_mem[i].ir;
            bus.a_brtype_pcpre_Buffer[i] = a_mem[i].brtype_pcpre;
            bus.b_brtype_pcpre_Buffer[i] = b_mem[i].brtype_pcpre;
            bus.a_ecode_Buffer[i]        = a_mem[i].ecode;
            bus.b_ecode_Buffer[i]        = b_mem[i].ecode;
        end
    end

`ifdef IBUF_PERF_CNT_EN
    logic [31:0] perf_q, perf_d;

    // Counts cycles where ID1 offers work but the buffer refuses it; survives flush.
    always_comb begin
        perf_d = perf_q;
        if ((n_push != 2'd0) && !bus.in_ready && (perf_q != '1)) begin
            perf_d = perf_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_q <= '0;
        end else begin
            perf_q <= perf_d;
        end
    end

    assign perf_stall_cnt = perf_q;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (bus.in_valid != 2'b10);
            assert (bus.out_pop != 2'b10);
        end
    end

endmodule

// File: tb/tb_id_inst_buffer_wr.sv
// Directed scoreboard bench for id_inst_buffer_wr; also checks perf_stall_cnt when IBUF_PERF_CNT_EN is set.
module tb_id_inst_buffer_wr;
    import ibuf_pkg::*;

    localparam int unsigned NUM = 16;
    localparam int unsigned CAP = 2 * NUM;

    logic clk = 1'b0;
    logic rst;
    logic flush;

    always #5 clk = ~clk;

    id_inst_buffer_wr_if #(.NUM(NUM)) bus ();

`ifdef IBUF_PERF_CNT_EN
    logic [31:0] perf;
`endif

    id_inst_buffer_wr #(.NUM(NUM), .CNT_W(6)) dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (bus)
`ifdef IBUF_PERF_CNT_EN
        ,
        .perf_stall_cnt (perf)
`endif
    );

    int          total = 0;
    int          bad   = 0;
    int          cnt_m;
    int          ta_m;
    int          tb_m;
    logic        rdb_m;
    logic        wb_m;
    logic [31:0] perf_m;
    logic [31:0] sb [$];
    logic [31:0] snap_a [NUM];
    logic [31:0] snap_b [NUM];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ir_of(input logic [31:0] pc);
        return pc ^ 32'hA5A5_0000;
    endfunction

    task automatic idle();
        bus.in_valid = 2'b00;
        bus.in_pc0 = '0; bus.in_pc1 = '0;
        bus.in_ir0 = '0; bus.in_ir1 = '0;
        bus.in_brtype_pcpre0 = '0; bus.in_brtype_pcpre1 = '0;
        bus.in_ecode0 = '0; bus.in_ecode1 = '0;
        bus.out_pop = 2'b00;
        flush = 1'b0;
    endtask

    task automatic model_reset(input logic hard);
        cnt_m = 0; ta_m = 0; tb_m = 0; rdb_m = 1'b0; wb_m = 1'b0;
        sb.delete();
        if (hard) perf_m = '0;
    endtask

    // Read k-th oldest entry (k=0 or 1) using the bench's own pointer model.
    task automatic rd_entry(input int k, output logic [31:0] pc, output logic [31:0] ir);
        logic bank;
        bank = rdb_m ^ (k == 1);
        if (!bank) begin pc = bus.a_PC_Buffer[ta_m]; ir = bus.a_IR_Buffer[ta_m]; end
        else       begin pc = bus.b_PC_Buffer[tb_m]; ir = bus.b_IR_Buffer[tb_m]; end
    endtask

    task automatic post_checks();
        check("out_valid", 64'(bus.out_valid), 64'({cnt_m >= 2, cnt_m >= 1}));
        check("rd_bank",   64'(bus.rd_bank), 64'(rdb_m));
        check("a_tail",    64'(bus.a_tail), 64'(16'h1 << ta_m));
        check("b_tail",    64'(bus.b_tail), 64'(16'h1 << tb_m));
        check("wr_bank",   64'(dut.wr_bank_q), 64'(wb_m));
`ifdef IBUF_PERF_CNT_EN
        check("perf", 64'(perf), 64'(perf_m));
`endif
    endtask

    // One clock of traffic; scoreboard pushes on acceptance and pops/compares on retire.
    task automatic cyc(input logic [1:0] v, input logic [31:0] p0, input logic [31:0] p1,
                       input logic [1:0] pop, input logic fl);
        int n, m;
        logic acc;
        logic [31:0] pc, ir, exp_pc;
        n = (v == 2'b11) ? 2 : (v == 2'b01) ? 1 : 0;
        m = (pop == 2'b11) ? 2 : (pop == 2'b01) ? 1 : 0;
        total++;
        assert (m <= cnt_m) else begin
            bad++;
            $error("FAIL pop_precond observed=%0d expected<=%0d", m, cnt_m);
        end
        check("in_ready", 64'(bus.in_ready), 64'(cnt_m <= int'(CAP - 2)));
        acc = !fl && (cnt_m <= int'(CAP - 2)) && (n != 0);
        bus.in_valid = v;
        bus.in_pc0 = p0; bus.in_pc1 = p1;
        bus.in_ir0 = ir_of(p0); bus.in_ir1 = ir_of(p1);
        bus.in_brtype_pcpre0 = {2'b10, p0}; bus.in_brtype_pcpre1 = {2'b01, p1};
        bus.in_ecode0 = p0[7:0]; bus.in_ecode1 = p1[7:0];
        bus.out_pop = pop;
        flush = fl;
        if (!fl) begin
            for (int k = 0; k < m; k++) begin
                rd_entry(k, pc, ir);
                exp_pc = (sb.size() > 0) ? sb.pop_front() : 32'hBAD0_BAD0;
                check("pop_pc", 64'(pc), 64'(exp_pc));
                check("pop_ir", 64'(ir), 64'(ir_of(exp_pc)));
            end
        end
        if (acc) begin
            sb.push_back(p0);
            if (n == 2) sb.push_back(p1);
        end
        if ((n != 0) && !(cnt_m <= int'(CAP - 2)) && (perf_m != 32'hFFFF_FFFF)) perf_m++;
        @(posedge clk); #1;
        idle();
        if (fl) begin
            model_reset(1'b0);
        end else begin
            cnt_m = cnt_m + (acc ? n : 0) - m;
            if (acc && n == 1) wb_m = ~wb_m;
            if (m == 2) begin
                ta_m = (ta_m + 1) % NUM; tb_m = (tb_m + 1) % NUM;
            end else if (m == 1) begin
                if (!rdb_m) ta_m = (ta_m + 1) % NUM; else tb_m = (tb_m + 1) % NUM;
                rdb_m = ~rdb_m;
            end
        end
        post_checks();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset(1'b1);
    endtask

    initial begin
        idle();
        model_reset(1'b1);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        check("rst_in_ready", 64'(bus.in_ready), 64'(1));
        post_checks();
        check("rst_a_pc0", 64'(bus.a_PC_Buffer[0]), 64'(0));
        check("rst_count", 64'(dut.count_q), 64'(0));

        // First dual push
        cyc(2'b11, 32'h1C00_0000, 32'h1C00_0004, 2'b00, 1'b0);
        check("push11_a0", 64'(bus.a_PC_Buffer[0]), 64'h1C00_0000);
        check("push11_b0", 64'(bus.b_PC_Buffer[0]), 64'h1C00_0004);
        check("push11_brp_b0", 64'(bus.b_brtype_pcpre_Buffer[0]), 64'({2'b01, 32'h1C00_0004}));

        // Single pushes alternate banks
        do_reset();
        cyc(2'b01, 32'h10, 32'h0, 2'b00, 1'b0);
        cyc(2'b01, 32'h14, 32'h0, 2'b00, 1'b0);
        check("single_a0", 64'(bus.a_PC_Buffer[0]), 64'h10);
        check("single_b0", 64'(bus.b_PC_Buffer[0]), 64'h14);
        cyc(2'b00, 32'h0, 32'h0, 2'b01, 1'b0);
        check("pop1_a_tail", 64'(bus.a_tail), 64'h2);
        cyc(2'b00, 32'h0, 32'h0, 2'b01, 1'b0);

        // Fill to capacity, then offer a push while full
        do_reset();
        for (int i = 0; i < 16; i++)
            cyc(2'b11, 32'h1000 + 32'(8 * i), 32'h1004 + 32'(8 * i), 2'b00, 1'b0);
        check("full_count", 64'(dut.count_q), 64'(32));
        for (int i = 0; i < NUM; i++) begin
            snap_a[i] = bus.a_PC_Buffer[i];
            snap_b[i] = bus.b_PC_Buffer[i];
        end
        cyc(2'b11, 32'hDEAD_0000, 32'hDEAD_0004, 2'b00, 1'b0);
        check("full_a0_kept", 64'(bus.a_PC_Buffer[0]), 64'(snap_a[0]));
        check("full_b0_kept", 64'(bus.b_PC_Buffer[0]), 64'(snap_b[0]));
        check("full_count2", 64'(dut.count_q), 64'(32));

        // Drain to 8, then steady traffic across the pointer wrap
        repeat (12) cyc(2'b00, 32'h0, 32'h0, 2'b11, 1'b0);
        for (int i = 0; i < 40; i++) begin
            cyc(2'b11, 32'h2000 + 32'(8 * i), 32'h2004 + 32'(8 * i), 2'b11, 1'b0);
            check("steady_count", 64'(dut.count_q), 64'(8));
        end
        cyc(2'b00, 32'h0, 32'h0, 2'b01, 1'b0);
        check("pre_flush_count", 64'(dut.count_q), 64'(7));

        // Flush with a simultaneous push
        for (int i = 0; i < NUM; i++) begin
            snap_a[i] = bus.a_PC_Buffer[i];
            snap_b[i] = bus.b_PC_Buffer[i];
        end
        cyc(2'b11, 32'hF000_0000, 32'hF000_0004, 2'b00, 1'b1);
        check("flush_count", 64'(dut.count_q), 64'(0));
        for (int i = 0; i < NUM; i++) begin
            check("flush_a_kept", 64'(bus.a_PC_Buffer[i]), 64'(snap_a[i]));
            check("flush_b_kept", 64'(bus.b_PC_Buffer[i]), 64'(snap_b[i]));
        end

        // Build up to 12 (plus one full-stall-free cycle), then reset mid-traffic
        for (int i = 0; i < 6; i++)
            cyc(2'b11, 32'h3000 + 32'(8 * i), 32'h3004 + 32'(8 * i), 2'b00, 1'b0);
        check("pre_rst_count", 64'(dut.count_q), 64'(12));
        bus.in_valid = 2'b11; bus.in_pc0 = 32'h4000; bus.in_pc1 = 32'h4004;
        bus.out_pop = 2'b01;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        idle();
        model_reset(1'b1);
        check("rst2_in_ready", 64'(bus.in_ready), 64'(1));
        check("rst2_count", 64'(dut.count_q), 64'(0));
        post_checks();
        for (int i = 0; i < NUM; i++) begin
            check("rst2_a_pc", 64'(bus.a_PC_Buffer[i]), 64'(0));
            check("rst2_b_pc", 64'(bus.b_PC_Buffer[i]), 64'(0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
